// File: rtl/hockey_param_if.sv
// hockey_param_if
// Groups the player controls and the display/score outputs of the air-hockey
// core into one bundle.
//   BTN_A/BTN_B    : hit/serve requests (level)
//   DIR_A/DIR_B    : shot direction (0 straight, 1 up, 2 down, 3 straight)
//   Y_in_A/Y_in_B  : paddle rows
//   X_COORD/Y_COORD: puck position
//   SCORE_A/SCORE_B: scores
//   STATE          : game state encoding
//   GAME_OVER      : high once the game has ended
//   WINNER         : 0 = A, 1 = B (meaningful with GAME_OVER)
// master = player/display side, slave = game core.
interface hockey_param_if #(
    parameter int CW = 3,
    parameter int SW = 2
);
    logic          BTN_A;
    logic          BTN_B;
    logic [1:0]    DIR_A;
    logic [1:0]    DIR_B;
    logic [CW-1:0] Y_in_A;
    logic [CW-1:0] Y_in_B;
    logic [CW-1:0] X_COORD;
    logic [CW-1:0] Y_COORD;
    logic [SW-1:0] SCORE_A;
    logic [SW-1:0] SCORE_B;
    logic [3:0]    STATE;
    logic          GAME_OVER;
    logic          WINNER;

    modport master (
        output BTN_A, BTN_B, DIR_A, DIR_B, Y_in_A, Y_in_B,
        input  X_COORD, Y_COORD, SCORE_A, SCORE_B, STATE, GAME_OVER, WINNER
    );

    modport slave (
        input  BTN_A, BTN_B, DIR_A, DIR_B, Y_in_A, Y_in_B,
        output X_COORD, Y_COORD, SCORE_A, SCORE_B, STATE, GAME_OVER, WINNER
    );
endinterface

// File: rtl/hockey_param.sv
// hockey_param
// Parametrised two-player air-hockey game core. Player A defends column 0,
// player B defends column X_MAX. The puck steps once every MOVE_DIV cycles,
// bounces off the top/bottom walls, and the defender gets RESP_WIN cycles to
// return it. First to WIN_SCORE ends the game.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   io  : hockey_param_if slave (player inputs, puck/score/state outputs)
//
// state   | meaning
// --------+---------------------------------------------
// IDLE    | waiting for either player to request a serve
// SERVE_A | A holds the puck at column 0, waiting for a valid row
// SERVE_B | B holds the puck at column X_MAX
// TRAV_B  | puck moving toward B
// RESP_B  | puck at B's column, B's hit window open
// TRAV_A  | puck moving toward A
// RESP_A  | puck at A's column, A's hit window open
// GOAL_A  | A scored, hold-off
// GOAL_B  | B scored, hold-off
// OVER    | game ended, everything frozen until reset
module hockey_param #(
    parameter int X_MAX     = 4,
    parameter int Y_MAX     = 4,
    parameter int CW        = 3,
    parameter int MOVE_DIV  = 2,
    parameter int RESP_WIN  = 4,
    parameter int GOAL_HOLD = 3,
    parameter int WIN_SCORE = 3,
    parameter int SW        = 2
) (
    input  logic          clk,
    input  logic          rst,
    hockey_param_if.slave io
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SERVE_A = 4'd1,
        S_SERVE_B = 4'd2,
        S_TRAV_B  = 4'd3,
        S_RESP_B  = 4'd4,
        S_TRAV_A  = 4'd5,
        S_RESP_A  = 4'd6,
        S_GOAL_A  = 4'd7,
        S_GOAL_B  = 4'd8,
        S_OVER    = 4'd9
    } state_t;

    // One shared down-timer serves step pacing, hit window and goal hold,
    // since only one of them is ever active at a time.
    localparam int T_MAX = (MOVE_DIV > RESP_WIN)
                         ? ((MOVE_DIV > GOAL_HOLD) ? MOVE_DIV : GOAL_HOLD)
                         : ((RESP_WIN > GOAL_HOLD) ? RESP_WIN : GOAL_HOLD);
    localparam int TW = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [CW-1:0] X_LAST    = CW'(X_MAX);
    localparam logic [CW-1:0] Y_LAST    = CW'(Y_MAX);
    localparam logic [CW-1:0] Y_MID     = CW'(Y_MAX / 2);
    localparam logic [SW-1:0] SCORE_END = SW'(WIN_SCORE);
    localparam logic [TW-1:0] LD_MOVE   = TW'(MOVE_DIV - 1);
    localparam logic [TW-1:0] LD_RESP   = TW'(RESP_WIN - 1);
    localparam logic [TW-1:0] LD_HOLD   = TW'(GOAL_HOLD - 1);
    localparam logic [1:0]    DIR_UP    = 2'd1;
    localparam logic [1:0]    DIR_DN    = 2'd2;

    state_t        state, state_nxt;
    logic [CW-1:0] x, y, x_nxt, y_nxt;
    logic [1:0]    dir, dir_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic [SW-1:0] score_a, score_b, score_a_nxt, score_b_nxt;
    logic          over, over_nxt, winner, winner_nxt;

    logic tmr_done, serve_ok_a, serve_ok_b, row_ok_a, row_ok_b;
    logic land_a, land_b, entering;

    assign tmr_done   = (tmr == '0);
    assign serve_ok_a = io.BTN_A && (io.Y_in_A <= Y_LAST);
    assign serve_ok_b = io.BTN_B && (io.Y_in_B <= Y_LAST);
    assign row_ok_a   = (io.Y_in_A == y);
    assign row_ok_b   = (io.Y_in_B == y);
    assign land_b     = (x == X_LAST - 1'b1);
    assign land_a     = (x == CW'(1));
    assign entering   = (state_nxt != state);

    // Direction code 3 behaves as a straight shot.
    function automatic logic [1:0] dir_sel(input logic [1:0] d);
        return (d == 2'd3) ? 2'd0 : d;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            x       <= '0;
            y       <= '0;
            dir     <= '0;
            tmr     <= '0;
            score_a <= '0;
            score_b <= '0;
            over    <= 1'b0;
            winner  <= 1'b0;
        end else begin
            state   <= state_nxt;
            x       <= x_nxt;
            y       <= y_nxt;
            dir     <= dir_nxt;
            tmr     <= tmr_nxt;
            score_a <= score_a_nxt;
            score_b <= score_b_nxt;
            over    <= over_nxt;
            winner  <= winner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (io.BTN_A)      state_nxt = S_SERVE_A;
                else if (io.BTN_B) state_nxt = S_SERVE_B;
            end
            S_SERVE_A: if (serve_ok_a) state_nxt = S_TRAV_B;
            S_SERVE_B: if (serve_ok_b) state_nxt = S_TRAV_A;
            S_TRAV_B:  if (tmr_done && land_b) state_nxt = S_RESP_B;
            S_TRAV_A:  if (tmr_done && land_a) state_nxt = S_RESP_A;
            S_RESP_B: begin
                // A press always resolves the window; timeout only without one.
                if (io.BTN_B)     state_nxt = row_ok_b ? S_TRAV_A : S_GOAL_A;
                else if (tmr_done) state_nxt = S_GOAL_A;
            end
            S_RESP_A: begin
                if (io.BTN_A)     state_nxt = row_ok_a ? S_TRAV_B : S_GOAL_B;
                else if (tmr_done) state_nxt = S_GOAL_B;
            end
            S_GOAL_A: if (tmr_done) state_nxt = (score_a == SCORE_END) ? S_OVER : S_SERVE_B;
            S_GOAL_B: if (tmr_done) state_nxt = (score_b == SCORE_END) ? S_OVER : S_SERVE_A;
            S_OVER:   state_nxt = S_OVER;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        x_nxt       = x;
        y_nxt       = y;
        dir_nxt     = dir;
        tmr_nxt     = tmr;
        score_a_nxt = score_a;
        score_b_nxt = score_b;
        over_nxt    = over;
        winner_nxt  = winner;

        if (entering) begin
            case (state_nxt)
                S_TRAV_A, S_TRAV_B: tmr_nxt = LD_MOVE;
                S_RESP_A, S_RESP_B: tmr_nxt = LD_RESP;
                S_GOAL_A, S_GOAL_B: tmr_nxt = LD_HOLD;
                default:            tmr_nxt = '0;
            endcase
        end else if (tmr_done) begin
            if (state == S_TRAV_A || state == S_TRAV_B) tmr_nxt = LD_MOVE;
        end else begin
            tmr_nxt = tmr - 1'b1;
        end

        case (state)
            S_IDLE, S_GOAL_A, S_GOAL_B: begin
                if (state_nxt == S_SERVE_A) begin
                    x_nxt = '0;
                    y_nxt = Y_MID;
                end else if (state_nxt == S_SERVE_B) begin
                    x_nxt = X_LAST;
                    y_nxt = Y_MID;
                end
            end
            S_SERVE_A: begin
                if (serve_ok_a) begin
                    y_nxt   = io.Y_in_A;
                    dir_nxt = dir_sel(io.DIR_A);
                end
            end
            S_SERVE_B: begin
                if (serve_ok_b) begin
                    y_nxt   = io.Y_in_B;
                    dir_nxt = dir_sel(io.DIR_B);
                end
            end
            S_TRAV_A, S_TRAV_B: begin
                if (tmr_done) begin
                    x_nxt = (state == S_TRAV_B) ? x + 1'b1 : x - 1'b1;
                    // Wall hit reflects the step and flips the direction.
                    if (Y_MAX > 0) begin
                        if (dir == DIR_UP) begin
                            if (y >= Y_LAST) begin
                                y_nxt   = y - 1'b1;
                                dir_nxt = DIR_DN;
                            end else begin
                                y_nxt = y + 1'b1;
                            end
                        end else if (dir == DIR_DN) begin
                            if (y == '0) begin
                                y_nxt   = y + 1'b1;
                                dir_nxt = DIR_UP;
                            end else begin
                                y_nxt = y - 1'b1;
                            end
                        end
                    end
                end
            end
            S_RESP_B: begin
                if (io.BTN_B && row_ok_b)     dir_nxt = dir_sel(io.DIR_B);
                else if (state_nxt == S_GOAL_A) score_a_nxt = score_a + 1'b1;
            end
            S_RESP_A: begin
                if (io.BTN_A && row_ok_a)     dir_nxt = dir_sel(io.DIR_A);
                else if (state_nxt == S_GOAL_B) score_b_nxt = score_b + 1'b1;
            end
            default: ;
        endcase

        if (entering && state_nxt == S_OVER) begin
            over_nxt   = 1'b1;
            winner_nxt = (state == S_GOAL_B);
        end
    end

    assign io.X_COORD   = x;
    assign io.Y_COORD   = y;
    assign io.SCORE_A   = score_a;
    assign io.SCORE_B   = score_b;
    assign io.STATE     = state;
    assign io.GAME_OVER = over;
    assign io.WINNER    = winner;
endmodule

// File: tb/tb_hockey_param.sv
// tb_hockey_param
// Bench for hockey_param: a default-parameter instance and a wide, fast
// instance (X_MAX=7, Y_MAX=6, MOVE_DIV=1) run side by side. A game model
// written from the rules predicts every output every cycle; directed steps
// follow the game scenarios, then random play runs against the model.
module tb_hockey_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hockey_param_if #(.CW(3), .SW(2)) if0 ();
    hockey_param_if #(.CW(3), .SW(2)) if1 ();

    hockey_param dut0 (.clk(clk), .rst(rst), .io(if0));
    hockey_param #(.X_MAX(7), .Y_MAX(6), .CW(3), .MOVE_DIV(1)) dut1 (.clk(clk), .rst(rst), .io(if1));

    int total = 0;
    int bad   = 0;

    // model parameters per instance
    int p_x[2]    = '{4, 7};
    int p_y[2]    = '{4, 6};
    int p_div[2]  = '{2, 1};
    int p_rw[2]   = '{4, 4};
    int p_hold[2] = '{3, 3};
    int p_win[2]  = '{3, 3};

    // model state: st is the state number, cnt counts cycles spent so far
    int m_st[2], m_x[2], m_y[2], m_dy[2], m_cnt[2], m_sa[2], m_sb[2], m_go[2], m_w[2];

    int by[4]  = '{2, 3, 4, 3};
    int ry[4]  = '{2, 1, 0, 1};
    int b1y[7] = '{2, 3, 4, 5, 6, 5, 4};

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int dmove(input int d);
        if (d == 1) return 1;
        if (d == 2) return -1;
        return 0;
    endfunction

    task automatic model_step(input int k, input int r, input int ba, input int bb,
                              input int da, input int db, input int ya, input int yb);
        int st, x, y, dy, cnt, sa, sb, ny;
        st = m_st[k]; x = m_x[k]; y = m_y[k]; dy = m_dy[k];
        cnt = m_cnt[k]; sa = m_sa[k]; sb = m_sb[k];
        if (r != 0) begin
            st = 0; x = 0; y = 0; dy = 0; cnt = 0; sa = 0; sb = 0;
            m_go[k] = 0; m_w[k] = 0;
        end else begin
            case (st)
                0: if (ba != 0 || bb != 0) begin
                    st = (ba != 0) ? 1 : 2;
                    x  = (ba != 0) ? 0 : p_x[k];
                    y  = p_y[k] / 2;
                end
                1: if (ba != 0 && ya <= p_y[k]) begin
                    y = ya; dy = dmove(da); st = 3; cnt = 0;
                end
                2: if (bb != 0 && yb <= p_y[k]) begin
                    y = yb; dy = dmove(db); st = 5; cnt = 0;
                end
                3, 5: begin
                    cnt++;
                    if (cnt == p_div[k]) begin
                        cnt = 0;
                        x = x + ((st == 3) ? 1 : -1);
                        ny = y + dy;
                        if (p_y[k] == 0) ny = 0;
                        else if (ny > p_y[k]) begin ny = p_y[k] - 1; dy = -1; end
                        else if (ny < 0) begin ny = 1; dy = 1; end
                        y = ny;
                        if (st == 3 && x == p_x[k]) st = 4;
                        else if (st == 5 && x == 0) st = 6;
                    end
                end
                4: begin
                    cnt++;
                    if (bb != 0) begin
                        if (yb == y) begin dy = dmove(db); st = 5; end
                        else begin sa++; st = 7; end
                        cnt = 0;
                    end else if (cnt == p_rw[k]) begin
                        sa++; st = 7; cnt = 0;
                    end
                end
                6: begin
                    cnt++;
                    if (ba != 0) begin
                        if (ya == y) begin dy = dmove(da); st = 3; end
                        else begin sb++; st = 8; end
                        cnt = 0;
                    end else if (cnt == p_rw[k]) begin
                        sb++; st = 8; cnt = 0;
                    end
                end
                7: begin
                    cnt++;
                    if (cnt == p_hold[k]) begin
                        cnt = 0;
                        if (sa == p_win[k]) begin st = 9; m_go[k] = 1; m_w[k] = 0; end
                        else begin st = 2; x = p_x[k]; y = p_y[k] / 2; end
                    end
                end
                8: begin
                    cnt++;
                    if (cnt == p_hold[k]) begin
                        cnt = 0;
                        if (sb == p_win[k]) begin st = 9; m_go[k] = 1; m_w[k] = 1; end
                        else begin st = 1; x = 0; y = p_y[k] / 2; end
                    end
                end
                default: ;
            endcase
        end
        m_st[k] = st; m_x[k] = x; m_y[k] = y; m_dy[k] = dy;
        m_cnt[k] = cnt; m_sa[k] = sa; m_sb[k] = sb;
    endtask

    task automatic cmp_all(input int k, input int st, input int x, input int y,
                           input int sa, input int sb, input int go, input int w);
        chk($sformatf("d%0d_state", k), st, m_st[k]);
        chk($sformatf("d%0d_x", k), x, m_x[k]);
        chk($sformatf("d%0d_y", k), y, m_y[k]);
        chk($sformatf("d%0d_score_a", k), sa, m_sa[k]);
        chk($sformatf("d%0d_score_b", k), sb, m_sb[k]);
        chk($sformatf("d%0d_game_over", k), go, m_go[k]);
        chk($sformatf("d%0d_winner", k), w, m_w[k]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, int'(rst), int'(if0.BTN_A), int'(if0.BTN_B), int'(if0.DIR_A),
                   int'(if0.DIR_B), int'(if0.Y_in_A), int'(if0.Y_in_B));
        model_step(1, int'(rst), int'(if1.BTN_A), int'(if1.BTN_B), int'(if1.DIR_A),
                   int'(if1.DIR_B), int'(if1.Y_in_A), int'(if1.Y_in_B));
        @(negedge clk);
        cmp_all(0, int'(if0.STATE), int'(if0.X_COORD), int'(if0.Y_COORD), int'(if0.SCORE_A),
                int'(if0.SCORE_B), int'(if0.GAME_OVER), int'(if0.WINNER));
        cmp_all(1, int'(if1.STATE), int'(if1.X_COORD), int'(if1.Y_COORD), int'(if1.SCORE_A),
                int'(if1.SCORE_B), int'(if1.GAME_OVER), int'(if1.WINNER));
    endtask

    task automatic drive0(input int ba, input int bb, input int da, input int db,
                          input int ya, input int yb);
        if0.BTN_A = (ba != 0); if0.BTN_B = (bb != 0);
        if0.DIR_A = 2'(da);    if0.DIR_B = 2'(db);
        if0.Y_in_A = 3'(ya);   if0.Y_in_B = 3'(yb);
    endtask

    task automatic drive1(input int ba, input int bb, input int da, input int db,
                          input int ya, input int yb);
        if1.BTN_A = (ba != 0); if1.BTN_B = (bb != 0);
        if1.DIR_A = 2'(da);    if1.DIR_B = 2'(db);
        if1.Y_in_A = 3'(ya);   if1.Y_in_B = 3'(yb);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_x[k] = 0; m_y[k] = 0; m_dy[k] = 0; m_cnt[k] = 0;
            m_sa[k] = 0; m_sb[k] = 0; m_go[k] = 0; m_w[k] = 0;
        end
        drive0(0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("reset_state", int'(if0.STATE), 0);
        chk("reset_x", int'(if0.X_COORD), 0);
        chk("reset_y", int'(if0.Y_COORD), 0);
        chk("reset_score_a", int'(if0.SCORE_A), 0);
        chk("reset_score_b", int'(if0.SCORE_B), 0);
        chk("reset_game_over", int'(if0.GAME_OVER), 0);

        // serve from A, row 1 upward, bounce off the top wall
        drive0(1, 0, 1, 0, 1, 0);
        tick();
        chk("serve_a_state", int'(if0.STATE), 1);
        chk("serve_a_y_mid", int'(if0.Y_COORD), 2);
        tick();
        chk("serve_trav_state", int'(if0.STATE), 3);
        chk("serve_trav_y", int'(if0.Y_COORD), 1);
        drive0(0, 0, 0, 0, 0, 0);
        for (int s = 1; s <= 4; s++) begin
            tick(); tick();
            chk("bounce_x", int'(if0.X_COORD), s);
            chk("bounce_y", int'(if0.Y_COORD), by[s-1]);
        end
        chk("arrive_resp_b", int'(if0.STATE), 4);

        // B returns downward on the first window cycle, floor bounce
        drive0(0, 1, 0, 2, 0, 3);
        tick();
        chk("return_state", int'(if0.STATE), 5);
        drive0(0, 0, 0, 0, 0, 0);
        for (int s = 1; s <= 4; s++) begin
            tick(); tick();
            chk("return_x", int'(if0.X_COORD), 4 - s);
            chk("return_y", int'(if0.Y_COORD), ry[s-1]);
        end
        chk("arrive_resp_a", int'(if0.STATE), 6);

        // A returns straight at row 1; B lets the window expire
        drive0(1, 0, 0, 0, 1, 0);
        tick();
        drive0(0, 0, 0, 0, 0, 0);
        repeat (8) tick();
        chk("straight_resp_b", int'(if0.STATE), 4);
        repeat (3) tick();
        chk("window_last_cycle", int'(if0.STATE), 4);
        tick();
        chk("timeout_goal", int'(if0.STATE), 7);
        chk("timeout_score", int'(if0.SCORE_A), 1);
        repeat (2) begin
            tick();
            chk("goal_hold", int'(if0.STATE), 7);
        end
        tick();
        chk("serve_b_state", int'(if0.STATE), 2);
        chk("serve_b_x", int'(if0.X_COORD), 4);
        chk("serve_b_y", int'(if0.Y_COORD), 2);

        // wrong-row misses until A wins
        for (int r = 0; r < 2; r++) begin
            drive0(0, 1, 0, 0, 0, 3);
            tick();
            drive0(0, 0, 0, 0, 0, 0);
            repeat (8) tick();
            drive0(1, 0, 0, 0, 3, 0);
            tick();
            drive0(0, 0, 0, 0, 0, 0);
            repeat (8) tick();
            drive0(0, 1, 0, 0, 0, 2);
            tick();
            chk("wrong_row_goal", int'(if0.STATE), 7);
            chk("wrong_row_score", int'(if0.SCORE_A), 2 + r);
            drive0(0, 0, 0, 0, 0, 0);
            repeat (3) tick();
        end
        chk("over_state", int'(if0.STATE), 9);
        chk("over_flag", int'(if0.GAME_OVER), 1);
        chk("over_winner", int'(if0.WINNER), 0);
        repeat (10) begin
            drive0(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            tick();
        end
        chk("frozen_state", int'(if0.STATE), 9);
        chk("frozen_x", int'(if0.X_COORD), 4);
        chk("frozen_y", int'(if0.Y_COORD), 3);
        chk("frozen_score", int'(if0.SCORE_A), 3);

        // both buttons in IDLE, then reset mid-travel
        drive0(0, 0, 0, 0, 0, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        drive0(1, 1, 1, 0, 2, 0);
        tick();
        chk("both_buttons", int'(if0.STATE), 1);
        tick();
        drive0(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("mid_trav_x", int'(if0.X_COORD), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_reset_state", int'(if0.STATE), 0);
        chk("mid_reset_x", int'(if0.X_COORD), 0);
        chk("mid_reset_y", int'(if0.Y_COORD), 0);

        // wide grid, one step per cycle, reflection at row 6
        drive1(1, 0, 1, 0, 1, 0);
        tick();
        chk("wide_serve_y", int'(if1.Y_COORD), 3);
        tick();
        chk("wide_trav_state", int'(if1.STATE), 3);
        drive1(0, 0, 0, 0, 0, 0);
        for (int s = 1; s <= 7; s++) begin
            tick();
            chk("wide_x", int'(if1.X_COORD), s);
            chk("wide_y", int'(if1.Y_COORD), b1y[s-1]);
        end
        chk("wide_resp_b", int'(if1.STATE), 4);

        // random play against the model
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive0(int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 1) == 0) ? m_y[0] : int'($urandom_range(0, 7)),
                   ($urandom_range(0, 1) == 0) ? m_y[0] : int'($urandom_range(0, 7)));
            drive1(int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 1) == 0) ? m_y[1] : int'($urandom_range(0, 7)),
                   ($urandom_range(0, 1) == 0) ? m_y[1] : int'($urandom_range(0, 7)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
